// File: rtl/tx_ts_responder_if.sv
// ---------------------------------------------------------------------------
// tx_ts_responder_if
//
// Request/response bundle of the TX egress timestamp responder.
//   in_ts_req_valid        request strobe, one per packet SOP
//   in_ts_req_fingerprint  request fingerprint
//   in_tod                 time of day in the ts_clk domain
//   out_ts_valid           timestamp response strobe (no backpressure)
//   out_ts_fp              fingerprint of the response
//   out_ts_data            captured timestamp
//
// master: the side issuing requests and consuming responses.
// slave : the responder itself.
// ---------------------------------------------------------------------------
interface tx_ts_responder_if #(
    parameter int TS_FP_WIDTH = 20,
    parameter int TS_WIDTH    = 96
);

    logic                   in_ts_req_valid;
    logic [TS_FP_WIDTH-1:0] in_ts_req_fingerprint;
    logic [TS_WIDTH-1:0]    in_tod;
    logic                   out_ts_valid;
    logic [TS_FP_WIDTH-1:0] out_ts_fp;
    logic [TS_WIDTH-1:0]    out_ts_data;

    modport master (
        output in_ts_req_valid,
        output in_ts_req_fingerprint,
        output in_tod,
        input  out_ts_valid,
        input  out_ts_fp,
        input  out_ts_data
    );

    modport slave (
        input  in_ts_req_valid,
        input  in_ts_req_fingerprint,
        input  in_tod,
        output out_ts_valid,
        output out_ts_fp,
        output out_ts_data
    );

endinterface

// File: rtl/tx_ts_responder.sv
// ---------------------------------------------------------------------------
// tx_ts_responder
//
// Egress timestamp responder. Each request captures the time of day and is
// held in a small FIFO; exactly EGRESS_LATENCY cycles after the request was
// sampled, the timestamp is returned together with its fingerprint.
// Drop and fingerprint-sequence statistics are kept for CSR readout.
//
// Ports:
//   ts_clk            sole clock
//   ts_rst_n          asynchronous active-low reset
//   ts_if             tx_ts_responder_if.slave (request in, response out);
//                     its widths must match TS_FP_WIDTH / TS_WIDTH
//   stat_clr          synchronous clear of the statistics
//   stat_overflow     sticky, a request was dropped
//   stat_drop_cnt     dropped requests, saturating
//   stat_seq_err_cnt  fingerprint discontinuities, saturating
//   stat_pending      current FIFO occupancy
//
// Build option:
//   TX_TS_SEQ_CHECK_EN  when defined, fingerprint continuity is tracked and
//                       counted; otherwise stat_seq_err_cnt is tied to 0.
// ---------------------------------------------------------------------------
module tx_ts_responder #(
    parameter int TS_FP_WIDTH    = 20,
    parameter int TS_WIDTH       = 96,
    parameter int FIFO_DEPTH     = 16,
    parameter int EGRESS_LATENCY = 8
) (
    input  logic                          ts_clk,
    input  logic                          ts_rst_n,
    tx_ts_responder_if.slave              ts_if,
    input  logic                          stat_clr,
    output logic                          stat_overflow,
    output logic [15:0]                   stat_drop_cnt,
    output logic [15:0]                   stat_seq_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   stat_pending
);

    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    AGE_MATCH = 16'(EGRESS_LATENCY - 1);
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

    logic [15:0]            cyc;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            count;

    logic [TS_FP_WIDTH-1:0] fp_mem    [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    tod_mem   [FIFO_DEPTH];
    logic [15:0]            stamp_mem [FIFO_DEPTH];

    logic [15:0]            head_age;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    logic                   out_valid_q;
    logic [TS_FP_WIDTH-1:0] out_fp_q;
    logic [TS_WIDTH-1:0]    out_data_q;

    // Entries are stamped with the cycle index they become resident in
    // (cyc after the push edge). The head is released on the edge where its
    // age reaches EGRESS_LATENCY-1, so the registered response appears
    // exactly EGRESS_LATENCY edges after the request was sampled, and
    // EGRESS_LATENCY=1 needs no bypass path. A pop in a full cycle frees the
    // slot for a push on the same edge.
    always_comb begin
        head_age = cyc - stamp_mem[rd_ptr];
        full     = (count == DEPTH_CNT);
        pop      = (count != '0) && (head_age == AGE_MATCH);
        push     = ts_if.in_ts_req_valid && (!full || pop);
        drop     = ts_if.in_ts_req_valid && full && !pop;
    end

    // Payload storage needs no reset: validity is carried by the pointers.
    always_ff @(posedge ts_clk) begin
        if (push) begin
            fp_mem[wr_ptr]    <= ts_if.in_ts_req_fingerprint;
            tod_mem[wr_ptr]   <= ts_if.in_tod;
            stamp_mem[wr_ptr] <= cyc + 16'd1;
        end
    end

    // Cycle counter, FIFO bookkeeping and the registered response.
    always_ff @(posedge ts_clk or negedge ts_rst_n) begin
        if (!ts_rst_n) begin
            cyc         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_fp_q    <= '0;
            out_data_q  <= '0;
        end else begin
            cyc         <= cyc + 16'd1;
            out_valid_q <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                out_fp_q   <= fp_mem[rd_ptr];
                out_data_q <= tod_mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Drop statistics; a clear in the same cycle as a drop wins.
    always_ff @(posedge ts_clk or negedge ts_rst_n) begin
        if (!ts_rst_n) begin
            stat_overflow <= 1'b0;
            stat_drop_cnt <= '0;
        end else if (stat_clr) begin
            stat_overflow <= 1'b0;
            stat_drop_cnt <= '0;
        end else if (drop) begin
            stat_overflow <= 1'b1;
            if (stat_drop_cnt != 16'hFFFF) begin
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
        end
    end

`ifdef TX_TS_SEQ_CHECK_EN
    localparam logic [TS_FP_WIDTH-1:0] FP_ONE = TS_FP_WIDTH'(1);

    logic                   exp_valid;
    logic [TS_FP_WIDTH-1:0] exp_fp;
    logic                   seq_err;
    logic [15:0]            seq_err_cnt_q;

    assign seq_err = ts_if.in_ts_req_valid && exp_valid &&
                     (ts_if.in_ts_req_fingerprint != exp_fp);

    // The tracker follows every request, dropped or not, so a gap is
    // reported once and the stream then resynchronises. The first request
    // after reset only arms the tracker.
    always_ff @(posedge ts_clk or negedge ts_rst_n) begin
        if (!ts_rst_n) begin
            exp_valid     <= 1'b0;
            exp_fp        <= '0;
            seq_err_cnt_q <= '0;
        end else begin
            if (ts_if.in_ts_req_valid) begin
                exp_valid <= 1'b1;
                exp_fp    <= ts_if.in_ts_req_fingerprint + FP_ONE;
            end
            if (stat_clr) begin
                seq_err_cnt_q <= '0;
            end else if (seq_err && (seq_err_cnt_q != 16'hFFFF)) begin
                seq_err_cnt_q <= seq_err_cnt_q + 16'd1;
            end
        end
    end

    assign stat_seq_err_cnt = seq_err_cnt_q;
`else
    assign stat_seq_err_cnt = '0;
`endif

    assign stat_pending       = count;
    assign ts_if.out_ts_valid = out_valid_q;
    assign ts_if.out_ts_fp    = out_fp_q;
    assign ts_if.out_ts_data  = out_data_q;

endmodule

// File: tb/tb_tx_ts_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tx_ts_responder
//
// Two responder instances: A with the default geometry (depth 16, latency 8)
// and B small and slow (depth 4, latency 20) to reach the full boundary.
// Expected responses are queued when a request is driven and matched by a
// monitor when the responder answers, including the exact response cycle.
// ---------------------------------------------------------------------------
module tb_tx_ts_responder;

    localparam int FPW     = 20;
    localparam int TSW     = 96;
    localparam int DEPTH_A = 16;
    localparam int LAT_A   = 8;
    localparam int DEPTH_B = 4;
    localparam int LAT_B   = 20;
    localparam int AWA     = $clog2(DEPTH_A);
    localparam int AWB     = $clog2(DEPTH_B);

    typedef struct {
        logic [FPW-1:0] fp;
        logic [TSW-1:0] data;
        int             due;
    } exp_t;

    logic ts_clk = 1'b0;
    logic ts_rst_n;
    logic clr_a;
    logic clr_b;
    logic ovf_a;
    logic ovf_b;
    logic [15:0] drop_a;
    logic [15:0] drop_b;
    logic [15:0] seq_a;
    logic [15:0] seq_b;
    logic [AWA:0] pend_a;
    logic [AWB:0] pend_b;

    tx_ts_responder_if #(.TS_FP_WIDTH(FPW), .TS_WIDTH(TSW)) ifa ();
    tx_ts_responder_if #(.TS_FP_WIDTH(FPW), .TS_WIDTH(TSW)) ifb ();

    tx_ts_responder #(
        .TS_FP_WIDTH(FPW), .TS_WIDTH(TSW),
        .FIFO_DEPTH(DEPTH_A), .EGRESS_LATENCY(LAT_A)
    ) dut_a (
        .ts_clk(ts_clk), .ts_rst_n(ts_rst_n), .ts_if(ifa),
        .stat_clr(clr_a), .stat_overflow(ovf_a), .stat_drop_cnt(drop_a),
        .stat_seq_err_cnt(seq_a), .stat_pending(pend_a)
    );

    tx_ts_responder #(
        .TS_FP_WIDTH(FPW), .TS_WIDTH(TSW),
        .FIFO_DEPTH(DEPTH_B), .EGRESS_LATENCY(LAT_B)
    ) dut_b (
        .ts_clk(ts_clk), .ts_rst_n(ts_rst_n), .ts_if(ifb),
        .stat_clr(clr_b), .stat_overflow(ovf_b), .stat_drop_cnt(drop_b),
        .stat_seq_err_cnt(seq_b), .stat_pending(pend_b)
    );

    always #5 ts_clk = ~ts_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    logic [15:0] tb_cyc;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea;
    exp_t        eb;
    logic [FPW-1:0] m_exp;
    logic           m_valid;
    logic [15:0]    exp_seq_err;
    logic [TSW-1:0] last_tod_a;

    // Edge index since time zero, used to time responses.
    always @(posedge ts_clk) edge_cnt <= edge_cnt + 1;

    // Reference cycle counter: zero in reset, +1 per edge.
    always @(posedge ts_clk or negedge ts_rst_n) begin
        if (!ts_rst_n) tb_cyc <= 16'd0;
        else           tb_cyc <= tb_cyc + 16'd1;
    end

    // Scoreboard monitor for instance A.
    always @(negedge ts_clk) begin
        if (ts_rst_n) begin
            if (ifa.out_ts_valid) begin
                n_checks++;
                if (qa.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL resp_a_spurious: got fp=%h at edge %0d, expected no response", ifa.out_ts_fp, edge_cnt);
                end else begin
                    ea = qa.pop_front();
                    if (ifa.out_ts_fp !== ea.fp || ifa.out_ts_data !== ea.data || edge_cnt != ea.due) begin
                        n_errors++;
                        $display("[TB] FAIL resp_a: got fp=%h data=%h edge=%0d, expected fp=%h data=%h edge=%0d",
                                 ifa.out_ts_fp, ifa.out_ts_data, edge_cnt, ea.fp, ea.data, ea.due);
                    end
                end
            end else if (qa.size() != 0 && qa[0].due <= edge_cnt) begin
                n_checks++;
                n_errors++;
                ea = qa.pop_front();
                $display("[TB] FAIL resp_a_missing: got no response at edge %0d, expected fp=%h", edge_cnt, ea.fp);
            end
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge ts_clk) begin
        if (ts_rst_n) begin
            if (ifb.out_ts_valid) begin
                n_checks++;
                if (qb.size() == 0) begin
                    n_errors++;
                    $display("[TB] FAIL resp_b_spurious: got fp=%h at edge %0d, expected no response", ifb.out_ts_fp, edge_cnt);
                end else begin
                    eb = qb.pop_front();
                    if (ifb.out_ts_fp !== eb.fp || ifb.out_ts_data !== eb.data || edge_cnt != eb.due) begin
                        n_errors++;
                        $display("[TB] FAIL resp_b: got fp=%h data=%h edge=%0d, expected fp=%h data=%h edge=%0d",
                                 ifb.out_ts_fp, ifb.out_ts_data, edge_cnt, eb.fp, eb.data, eb.due);
                    end
                end
            end else if (qb.size() != 0 && qb[0].due <= edge_cnt) begin
                n_checks++;
                n_errors++;
                eb = qb.pop_front();
                $display("[TB] FAIL resp_b_missing: got no response at edge %0d, expected fp=%h", edge_cnt, eb.fp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One request on A for one cycle; call at posedge+1.
    task automatic drive_a(input logic [FPW-1:0] fp, input logic clr);
        exp_t e;
        e.fp   = fp;
        e.data = {$urandom(), $urandom(), $urandom()};
        e.due  = edge_cnt + 1 + LAT_A;
        last_tod_a = e.data;
        ifa.in_ts_req_valid       = 1'b1;
        ifa.in_ts_req_fingerprint = fp;
        ifa.in_tod                = e.data;
        clr_a                     = clr;
        qa.push_back(e);
        if (clr) exp_seq_err = 16'd0;
        else if (m_valid && fp != m_exp && exp_seq_err != 16'hFFFF) exp_seq_err = exp_seq_err + 16'd1;
        m_exp   = fp + FPW'(1);
        m_valid = 1'b1;
        @(posedge ts_clk);
        #1;
        ifa.in_ts_req_valid = 1'b0;
        clr_a               = 1'b0;
    endtask

    // One request on B; accept tells whether a response is expected.
    task automatic drive_b(input logic [FPW-1:0] fp, input logic accept);
        exp_t e;
        e.fp   = fp;
        e.data = {$urandom(), $urandom(), $urandom()};
        e.due  = edge_cnt + 1 + LAT_B;
        ifb.in_ts_req_valid       = 1'b1;
        ifb.in_ts_req_fingerprint = fp;
        ifb.in_tod                = e.data;
        if (accept) qb.push_back(e);
        @(posedge ts_clk);
        #1;
        ifb.in_ts_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (ifa.out_ts_valid !== 1'b0 || ifa.out_ts_fp !== '0 || ifa.out_ts_data !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_out_a: got v=%b fp=%h data=%h, expected all 0", ifa.out_ts_valid, ifa.out_ts_fp, ifa.out_ts_data);
        end
        n_checks++;
        if (pend_a !== '0 || drop_a !== 16'd0 || ovf_a !== 1'b0 || seq_a !== 16'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_stat_a: got pend=%0d drop=%0d ovf=%b seq=%0d, expected 0", pend_a, drop_a, ovf_a, seq_a);
        end
        n_checks++;
        if (ifb.out_ts_valid !== 1'b0 || pend_b !== '0 || drop_b !== 16'd0 || ovf_b !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_b: got v=%b pend=%0d drop=%0d ovf=%b, expected 0", ifb.out_ts_valid, pend_b, drop_b, ovf_b);
        end
        @(posedge ts_clk);
        #1;
        ts_rst_n = 1'b1;
    endtask

    task automatic test_single;
        int s;
        int got;
        repeat (10) begin @(posedge ts_clk); #1; end
        s = edge_cnt + 1;
        drive_a(20'h00005, 1'b0);
        got = -1;
        for (int i = 0; i < LAT_A + 5 && got < 0; i++) begin
            @(negedge ts_clk);
            if (ifa.out_ts_valid) got = edge_cnt;
        end
        n_checks++;
        if (got != s + LAT_A) begin
            n_errors++;
            $display("[TB] FAIL single_latency: got response at edge %0d, expected %0d", got, s + LAT_A);
        end
        @(negedge ts_clk);
        n_checks++;
        if (ifa.out_ts_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL single_pulse: got valid=%b one cycle later, expected 0", ifa.out_ts_valid);
        end
        n_checks++;
        if (ifa.out_ts_fp !== 20'h00005 || ifa.out_ts_data !== last_tod_a) begin
            n_errors++;
            $display("[TB] FAIL single_hold: got fp=%h data=%h, expected fp=00005 data=%h", ifa.out_ts_fp, ifa.out_ts_data, last_tod_a);
        end
        @(posedge ts_clk);
        #1;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) drive_a(FPW'(i), 1'b0);
        n_checks++;
        if (pend_a !== (AWA + 1)'((LAT_A < 8) ? LAT_A : 8)) begin
            n_errors++;
            $display("[TB] FAIL b2b_peak_pending: got %0d, expected %0d", pend_a, (LAT_A < 8) ? LAT_A : 8);
        end
        repeat (LAT_A + 4) begin @(posedge ts_clk); #1; end
        n_checks++;
        if (pend_a !== '0 || qa.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL b2b_drain: got pend=%0d outstanding=%0d, expected 0 and 0", pend_a, qa.size());
        end
    endtask

    task automatic test_overflow;
        int e0;
        e0 = edge_cnt + 1;
        for (int i = 0; i < 6; i++) drive_b(FPW'(100 + i), (i < 4) ? 1'b1 : 1'b0);
        n_checks++;
        if (drop_b !== 16'd2 || ovf_b !== 1'b1 || pend_b !== (AWB + 1)'(4)) begin
            n_errors++;
            $display("[TB] FAIL ovf_full: got drop=%0d ovf=%b pend=%0d, expected 2 1 4", drop_b, ovf_b, pend_b);
        end
        repeat (e0 + 19 - edge_cnt) begin @(posedge ts_clk); #1; end
        // These two land on the edges where the oldest entries leave a full FIFO.
        drive_b(FPW'(106), 1'b1);
        drive_b(FPW'(107), 1'b1);
        n_checks++;
        if (drop_b !== 16'd2 || pend_b !== (AWB + 1)'(4)) begin
            n_errors++;
            $display("[TB] FAIL ovf_push_pop: got drop=%0d pend=%0d, expected 2 4", drop_b, pend_b);
        end
        repeat (LAT_B + 6) begin @(posedge ts_clk); #1; end
        n_checks++;
        if (pend_b !== '0 || qb.size() != 0 || seq_b !== 16'd0) begin
            n_errors++;
            $display("[TB] FAIL ovf_drain: got pend=%0d outstanding=%0d seq=%0d, expected 0 0 0", pend_b, qb.size(), seq_b);
        end
        clr_b = 1'b1;
        @(posedge ts_clk);
        #1;
        clr_b = 1'b0;
        n_checks++;
        if (drop_b !== 16'd0 || ovf_b !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL ovf_clear: got drop=%0d ovf=%b, expected 0 0", drop_b, ovf_b);
        end
    endtask

    task automatic test_wrap;
        int guard;
        logic [15:0] resp_cyc;
        guard = 0;
        while (tb_cyc != 16'hFFFB && guard < 70000) begin
            @(posedge ts_clk);
            #1;
            guard++;
        end
        n_checks++;
        if (guard >= 70000) begin
            n_errors++;
            $display("[TB] FAIL wrap_reach: got cyc=%h, expected FFFB within bound", tb_cyc);
        end
        for (int i = 0; i < 4; i++) drive_a(m_exp, 1'b0);
        resp_cyc = 16'hDEAD;
        for (int i = 0; i < LAT_A + 4 && resp_cyc == 16'hDEAD; i++) begin
            @(negedge ts_clk);
            if (ifa.out_ts_valid) resp_cyc = tb_cyc;
        end
        n_checks++;
        if (resp_cyc !== 16'h0004) begin
            n_errors++;
            $display("[TB] FAIL wrap_first_resp: got cyc=%h, expected 0004", resp_cyc);
        end
        repeat (LAT_A + 4) begin @(posedge ts_clk); #1; end
        n_checks++;
        if (pend_a !== '0 || qa.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL wrap_drain: got pend=%0d outstanding=%0d, expected 0 0", pend_a, qa.size());
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        for (int i = 0; i < 3; i++) drive_a(m_exp, 1'b0);
        @(posedge ts_clk);
        #1;
        n_checks++;
        if (pend_a !== (AWA + 1)'(3)) begin
            n_errors++;
            $display("[TB] FAIL rmid_pending: got %0d, expected 3", pend_a);
        end
        ts_rst_n = 1'b0;
        #1;
        qa.delete();
        m_valid     = 1'b0;
        exp_seq_err = 16'd0;
        n_checks++;
        if (ifa.out_ts_valid !== 1'b0 || ifa.out_ts_fp !== '0 || ifa.out_ts_data !== '0 || pend_a !== '0) begin
            n_errors++;
            $display("[TB] FAIL rmid_async: got v=%b fp=%h data=%h pend=%0d, expected all 0",
                     ifa.out_ts_valid, ifa.out_ts_fp, ifa.out_ts_data, pend_a);
        end
        n_checks++;
        if (ifb.out_ts_fp !== '0 || ifb.out_ts_data !== '0) begin
            n_errors++;
            $display("[TB] FAIL rmid_async_b: got fp=%h data=%h, expected 0", ifb.out_ts_fp, ifb.out_ts_data);
        end
        repeat (2) @(posedge ts_clk);
        #1;
        ts_rst_n = 1'b1;
        seen = 0;
        repeat (LAT_A + 20) begin
            @(negedge ts_clk);
            if (ifa.out_ts_valid) seen++;
        end
        n_checks++;
        if (seen != 0 || pend_a !== '0 || ifa.out_ts_fp !== '0) begin
            n_errors++;
            $display("[TB] FAIL rmid_after: got responses=%0d pend=%0d fp=%h, expected 0 0 0", seen, pend_a, ifa.out_ts_fp);
        end
        @(posedge ts_clk);
        #1;
    endtask

    task automatic test_seq;
        logic [15:0] want;
        drive_a(20'h00001, 1'b0);
        drive_a(20'h00002, 1'b0);
        drive_a(20'h00003, 1'b0);
        drive_a(20'h00007, 1'b0);
        drive_a(20'h00008, 1'b0);
`ifdef TX_TS_SEQ_CHECK_EN
        want = exp_seq_err;
`else
        want = 16'd0;
`endif
        n_checks++;
        if (seq_a !== want) begin
            n_errors++;
            $display("[TB] FAIL seq_gap: got %0d, expected %0d", seq_a, want);
        end
        drive_a(20'h00009, 1'b0);
        drive_a(20'hFFFFF, 1'b0);
        drive_a(20'h00000, 1'b0);
`ifdef TX_TS_SEQ_CHECK_EN
        want = exp_seq_err;
`else
        want = 16'd0;
`endif
        n_checks++;
        if (seq_a !== want) begin
            n_errors++;
            $display("[TB] FAIL seq_fp_wrap: got %0d, expected %0d", seq_a, want);
        end
        // A gap in the same cycle as the clear must not be counted.
        drive_a(20'h12345, 1'b1);
        n_checks++;
        if (seq_a !== 16'd0) begin
            n_errors++;
            $display("[TB] FAIL seq_clear_wins: got %0d, expected 0", seq_a);
        end
        repeat (LAT_A + 4) begin @(posedge ts_clk); #1; end
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0 || pend_a !== '0) begin
            n_errors++;
            $display("[TB] FAIL final_drain: got outstanding a=%0d b=%0d pend=%0d, expected 0", qa.size(), qb.size(), pend_a);
        end
    endtask

    initial begin
        ts_rst_n                  = 1'b0;
        clr_a                     = 1'b0;
        clr_b                     = 1'b0;
        ifa.in_ts_req_valid       = 1'b0;
        ifa.in_ts_req_fingerprint = '0;
        ifa.in_tod                = '0;
        ifb.in_ts_req_valid       = 1'b0;
        ifb.in_ts_req_fingerprint = '0;
        ifb.in_tod                = '0;
        m_valid                   = 1'b0;
        m_exp                     = '0;
        exp_seq_err               = 16'd0;
        last_tod_a                = '0;
        repeat (3) @(posedge ts_clk);
        #1;
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_wrap;
        test_reset_mid;
        test_seq;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_ts_responder.md
# tx_ts_responder

Egress timestamp responder at the MAC end of the TX timestamp-request path. Accepts fingerprinted timestamp requests issued at packet SOP and captures the time of day at request. After a fixed egress latency, returns each timestamp with its fingerprint on the write side of the TX DMA FIFO's timestamp queue. Keeps drop and sequence statistics for CSR readout.

## Interface
Parameters:
- TS_FP_WIDTH, 20, fingerprint width.
- TS_WIDTH, 96, timestamp width ({48b sec, 32b ns, 16b frac ns}).
- FIFO_DEPTH, 16, pending-request entries; power of 2, 2..256.
- EGRESS_LATENCY, 8, request-to-response latency in ts_clk cycles; 1..32767.

Ports (reset is asynchronous and active-low):
- ts_clk  in  1  sole clock.
- ts_rst_n  in  1  asynchronous active-low reset.
- in_ts_req_valid  in  1  request strobe, one per packet SOP.
- in_ts_req_fingerprint  in  TS_FP_WIDTH  request fingerprint.
- in_tod  in  TS_WIDTH  current time of day, ts_clk domain.
- out_ts_valid  out  1  timestamp response strobe; no backpressure.
- out_ts_fp  out  TS_FP_WIDTH  fingerprint of response.
- out_ts_data  out  TS_WIDTH  captured timestamp.
- stat_clr  in  1  synchronous clear of statistics.
- stat_overflow  out  1  sticky: a request was dropped.
- stat_drop_cnt  out  16  dropped requests, saturating.
- stat_seq_err_cnt  out  16  fingerprint discontinuities, saturating.
- stat_pending  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- 16-bit free-running cycle counter cyc, +1 per cycle, wraps.
- On in_ts_req_valid with the FIFO not full: push {fingerprint, in_tod sampled that cycle, cyc}.
- On in_ts_req_valid with the FIFO full: request dropped, no push. Set stat_overflow. Increment stat_drop_cnt, saturating at 0xFFFF.
- Release: the head entry pops when (cyc - entry.cyc) mod 2^16 == EGRESS_LATENCY-1. The next cycle presents out_ts_valid=1 with the stored fp and data.
- At most one push and one pop per cycle. Order is FIFO. Because latency is fixed and pushes occur at most once per cycle, every entry releases exactly on time.
- Simultaneous push and pop when full: the pop frees the slot in the same cycle, so the push is accepted and nothing is dropped.
- Outside release cycles: out_ts_valid=0. out_ts_fp and out_ts_data hold their last values.
- stat_clr zeroes the counters and stat_overflow. An event in the same cycle as stat_clr is lost (the clear wins).
- stat_pending = entries pushed and not yet popped.

## Timing
- Reset values: out_ts_valid=0, out_ts_fp=0, out_ts_data=0, all stat_* outputs 0, cyc=0, FIFO empty, expected fingerprint invalid.
- Latency: a request sampled at edge N produces out_ts_valid high for exactly one cycle, N+EGRESS_LATENCY. All outputs are registered.
- Reset asserted mid-operation: all pending entries are discarded and no response is emitted for them. Outputs return to their reset values asynchronously.
- Full boundary: with FIFO_DEPTH requests outstanding and no release that cycle, the next request is dropped.
- Wrap-around: the age comparison is modulo 2^16 and stays correct across cyc wrap. EGRESS_LATENCY < 2^15 guarantees this.

## Configuration
- TX_TS_SEQ_CHECK_EN defined:
  - Track the expected fingerprint as last accepted fingerprint + 1, modulo 2^TS_FP_WIDTH.
  - A request (accepted or dropped) whose fingerprint differs from the expected value increments stat_seq_err_cnt, saturating.
  - The expected value is then resynchronised to the received fingerprint + 1.
  - The first request after reset only initialises the tracker and never counts as an error.
- TX_TS_SEQ_CHECK_EN undefined: no tracking logic; stat_seq_err_cnt tied to 0.

## Test plan
- Single request fp=0x00005 at cycle 10 with in_tod=T → out_ts_valid only at cycle 10+EGRESS_LATENCY, out_ts_fp=0x00005, out_ts_data=T.
- Back-to-back requests fp=0..7 on consecutive cycles → eight consecutive responses, in order, each exactly EGRESS_LATENCY later; stat_pending peaks at min(8, EGRESS_LATENCY).
- FIFO_DEPTH=4, EGRESS_LATENCY=20, six consecutive requests → first four answered, stat_drop_cnt=2, stat_overflow=1; stat_clr → both 0.
- Requests spanning a cyc wrap (first request at cyc=0xFFFC, EGRESS_LATENCY=8) → response at cyc=0x0004, no extra or missing responses.
- TX_TS_SEQ_CHECK_EN on: fingerprints 1,2,3,7,8 → stat_seq_err_cnt=1; fp 0xFFFFF then 0x00000 → no error. Macro off → stat_seq_err_cnt stays 0.
- Assert ts_rst_n low with 3 entries pending → no responses after reset release, stat_pending=0, all outputs 0.
